// File: rtl/servant_uart_rx.sv
// Wishbone-attached 8N1 UART receiver for the servant SoC.
// A fixed clocks-per-bit divider feeds a small byte FIFO; o_irq is high while data is pending.
module servant_uart_rx #(
  parameter int clks_per_bit    = 139,
  parameter int fifo_depth_log2 = 2
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  input  logic        i_uart_rx,
  output logic        o_irq
);

  // state     | meaning
  // IDLE      | waiting for a low level on rxs
  // START     | mid-start-bit recheck (glitch filter)
  // DATA      | sampling 8 data bits, LSB first
  // STOP      | sampling the stop bit
  // WAIT_HIGH | framing error seen; hold off until the line returns high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam int CW    = $clog2(clks_per_bit);
  localparam int D     = fifo_depth_log2;
  localparam int DEPTH = 1 << D;
  localparam logic [CW-1:0] HALF_LOAD = CW'(clks_per_bit / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(clks_per_bit - 1);

  logic          r_rx_meta;
  logic          r_rxs;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [DEPTH];
  logic [D:0]    r_wptr;
  logic [D:0]    r_rptr;
  logic          r_ovr;
  logic          r_ferr;

  logic          w_cnt_zero;
  logic          w_push_req;
  logic          w_ferr_set;
  logic [D:0]    w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_ack_cycle;
  logic          w_pop;
  logic          w_push;
  logic          w_ovr_set;
  logic          w_clr_ovr;
  logic          w_clr_ferr;
  logic [7:0]    w_head;
  logic [31:0]   w_status;
  logic          w_unused_dat;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_cnt_zero = (r_cnt == '0);
  assign w_push_req = (r_state == STOP) && w_cnt_zero && r_rxs;
  assign w_ferr_set = (r_state == STOP) && w_cnt_zero && !r_rxs;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_rxs) begin
            r_cnt   <= HALF_LOAD;
            r_state <= START;
          end
        end
        START: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_rxs) begin
            r_cnt     <= FULL_LOAD;
            r_bit_idx <= '0;
            r_state   <= DATA;
          end else begin
            r_state <= IDLE;
          end
        end
        DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_cnt   <= FULL_LOAD;
            if (r_bit_idx == 3'd7) r_state <= STOP;
            else r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        STOP: begin
          if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
          else r_state <= r_rxs ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (r_rxs) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (w_count == '0);
  assign w_full      = (w_count == (D + 1)'(DEPTH));
  assign w_ack_cycle = i_wb_cyc && !o_wb_ack;
  assign w_pop       = w_ack_cycle && !i_wb_we && !i_wb_adr && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovr_set   = w_push_req && w_full && !w_pop;
  assign w_clr_ovr   = w_ack_cycle && i_wb_we && i_wb_adr && i_wb_dat[1];
  assign w_clr_ferr  = w_ack_cycle && i_wb_we && i_wb_adr && i_wb_dat[2];
  assign w_head      = r_mem[r_rptr[D-1:0]];
  assign w_status    = {24'b0, 5'(w_count), r_ferr, r_ovr, !w_empty};
  assign w_unused_dat = ^{i_wb_dat[31:3], i_wb_dat[0]};

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr[D-1:0]] <= r_shift;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
      o_irq    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // Set wins over a simultaneous write-1-to-clear.
      r_ovr    <= (r_ovr && !w_clr_ovr) || w_ovr_set;
      r_ferr   <= (r_ferr && !w_clr_ferr) || w_ferr_set;
      o_wb_ack <= w_ack_cycle;
      if (w_ack_cycle) o_wb_rdt <= i_wb_adr ? w_status : {24'b0, w_empty ? 8'h00 : w_head};
      o_irq    <= !w_empty;
    end
  end

endmodule

// File: doc/servant_uart_rx.md
# servant_uart_rx

Wishbone-attached UART receiver for the servant SoC, the receive-side counterpart to the GPIO-driven `o_uart_tx` output on the board tops. It samples an asynchronous serial input (8N1, LSB first) using a fixed clocks-per-bit divider and assembles bytes. Received bytes are buffered in a small FIFO, and the CPU reads them through a single-cycle-ack Wishbone slave port. An interrupt level is raised whenever data is pending.

## Interface
- `clks_per_bit`, default 139 — `wb_clk` cycles per UART bit (16 MHz / 115200); minimum 8.
- `fifo_depth_log2`, default 2 — FIFO holds 2**`fifo_depth_log2` bytes (default 4).
- `wb_clk` input 1 — sole clock; all logic is on the rising edge.
- `wb_rst_n` input 1 — reset, asynchronous assert, active-low.
- `i_wb_adr` input 1 — register select (SoC address bit 2): 0 = DATA, 1 = STATUS.
- `i_wb_dat` input 32 — write data; only STATUS writes are meaningful.
- `i_wb_we` input 1 — write enable.
- `i_wb_cyc` input 1 — bus cycle request (combined cyc/stb).
- `o_wb_rdt` output 32 — read data, registered.
- `o_wb_ack` output 1 — one-cycle acknowledge.
- `i_uart_rx` input 1 — asynchronous serial line; idles high.
- `o_irq` output 1 — high while the FIFO is not empty.

## Operation
- **Input synchronizer:** `i_uart_rx` passes through 2 flops, each reset to 1. All receive logic uses the synchronized value `rxs`.
- **RX state machine: IDLE → START → DATA → STOP → (IDLE | WAIT_HIGH).**
  - **IDLE:** `rxs`==0 loads the bit counter with `clks_per_bit`/2−1 and enters START.
  - **START:** when the counter expires, re-sample `rxs`.
    - If 0, reload the counter with `clks_per_bit`−1, clear the bit index, and enter DATA.
    - If 1, the low pulse was a glitch; return to IDLE.
  - **DATA:** on each counter expiry, shift `rxs` into the shift register MSB-first-in, so bit 0 is received first. After the 8th sample, enter STOP with the counter reloaded.
  - **STOP:** on counter expiry, sample `rxs`.
    - If 1, push the byte and go to IDLE.
    - If 0, set `ferr` sticky, do not push, and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rxs`==1, then go to IDLE. This prevents a break condition from being decoded as 0x00 bytes.
- **FIFO:** circular buffer with read and write pointers of `fifo_depth_log2`+1 bits; `count` = wptr − rptr.
  - **Full:** a push while full with no simultaneous pop drops the byte and sets `ovr` sticky.
  - **Push and pop in the same cycle while full:** both occur, and `ovr` is not set.
  - **Pop while empty:** no effect.
- **Wishbone access:**
  - `o_wb_ack` <= `i_wb_cyc` & !`o_wb_ack`, giving exactly one ack per request, one cycle after `i_wb_cyc` rises.
  - `o_wb_rdt` is loaded in the same cycle that `o_wb_ack` is set.
  - **DATA read:** rdt[7:0] = head byte, or 0 if empty; rdt[31:8] = 0. The FIFO pops on the ack cycle.
  - **DATA write:** ignored, but still acked.
  - **STATUS read:**
    - bit0 = not empty
    - bit1 = `ovr`
    - bit2 = `ferr`
    - bits[7:3] = `count` (zero-extended)
    - bits[31:8] = 0
  - **STATUS write:** write-1-to-clear. `i_wb_dat`[1] clears `ovr` and `i_wb_dat`[2] clears `ferr`. A clear in the same cycle as a new set event leaves the flag set.
- `o_irq` = (`count` != 0), driven from a register.

## Timing
- **Reset values:**
  - `o_wb_ack`=0, `o_wb_rdt`=0, `o_irq`=0.
  - FIFO empty, `ovr`=0, `ferr`=0, state IDLE, synchronizer flops=1.
  - Reset asserted mid-frame aborts the frame, and the partial byte is lost.
- **Input latency:** pin to `rxs` is 2 cycles.
- **Frame latency:**
  - The falling edge of `rxs` to the START check is `clks_per_bit`/2 cycles.
  - Each data bit is then sampled every `clks_per_bit` cycles.
  - The push occurs at `clks_per_bit`/2 + 9·`clks_per_bit` cycles after the `rxs` falling edge.
  - `o_irq` rises 1 cycle after the push.
- **Back-to-back frames:** a new start bit is accepted from the cycle after the stop sample. A single stop bit is sufficient; no extra idle time is required.
- **Bus access:** the bus sees ack 1 cycle after the request. A DATA-read pop takes effect on that ack edge, so `count` and `o_irq` update 1 cycle later.

## Test plan
- Set `clks_per_bit`=16. Send 0xA5 as 8N1 → `o_irq` rises; STATUS = 0x09 (valid, count 1); DATA read = 0x000000A5; then STATUS = 0x00 and `o_irq`=0.
- Send 5 bytes 0x01..0x05 back-to-back with no reads → STATUS = 0x23 (count 4, `ovr`); DATA reads return 0x01..0x04; writing STATUS 0x2 clears `ovr` to 0.
- Send 0x3C with the stop bit forced to 0, then hold the line low for 40 cycles → no push, STATUS bit2=1; the next valid byte 0x7E is received correctly after the line returns high.
- Drive a 4-cycle low glitch on an idle line → state returns to IDLE; no push; STATUS = 0x00.
- Send frames 0x00 then 0xFF with one stop bit between them; read DATA during the second frame → reads return 0x00, then 0xFF; no `ferr` or `ovr`.
- Assert `wb_rst_n`=0 during bit 4 of a frame, then release → all outputs 0, FIFO empty; the next full frame 0x55 is received correctly.
